result_ascii_streamer: RTL and testbench

RESULT_ASCII_STREAMER -- requirements
Module: result_ascii_streamer

---
 rtl/result_ascii_streamer_pkg.sv | 27 ++
 rtl/result_ascii_streamer_if.sv | 25 ++
 rtl/result_ascii_streamer_bin2bcd_seq.sv | 48 ++++
 rtl/result_ascii_streamer.sv | 119 +++++++++++
 tb/tb_result_ascii_streamer.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/result_ascii_streamer_pkg.sv
// Shared types and constants for the result-to-ASCII streamer.
package result_ascii_streamer_pkg;

  localparam int unsigned NUM_DIGITS = 5;
  localparam int unsigned VALUE_W    = 16;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned BCD_W      = NUM_DIGITS * DIGIT_W;
  localparam int unsigned POS_W      = 3;
  localparam int unsigned CHAR_W     = 8;
  localparam int unsigned CNT_W      = 5;

  localparam logic [CHAR_W-1:0] ASCII_ZERO = 8'h30;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    EMIT    = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Extract decimal digit i (0 = most significant) from a packed BCD word.
  function automatic logic [DIGIT_W-1:0] bcd_digit(input logic [BCD_W-1:0] bcd,
                                                   input int unsigned     idx);
    bcd_digit = bcd[BCD_W-1-DIGIT_W*idx -: DIGIT_W];
  endfunction

endpackage

// File: rtl/result_ascii_streamer_if.sv
// Start/value request plus character stream handshake towards the LCD controller.
interface result_ascii_streamer_if;
  import result_ascii_streamer_pkg::*;

  logic                start;
  logic [VALUE_W-1:0]  value_i;
  logic                busy;
  logic                char_valid;
  logic                char_ready;
  logic [CHAR_W-1:0]   char_data;
  logic [POS_W-1:0]    char_pos;
  logic                done;

  // Requester / LCD side
  modport master (
    output start, value_i, char_ready,
    input  busy, char_valid, char_data, char_pos, done
  );

  // Streamer side
  modport slave (
    input  start, value_i, char_ready,
    output busy, char_valid, char_data, char_pos, done
  );
endinterface

// File: rtl/result_ascii_streamer_bin2bcd_seq.sv
// Iterative double-dabble converter: one shift-add-3 step per clock after load.
module bin2bcd_seq
  import result_ascii_streamer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [VALUE_W-1:0] bin,
  output logic [BCD_W-1:0]   bcd,
  output logic               ready
);

  logic [VALUE_W-1:0] bin_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [BCD_W-1:0]   bcd_adj;
  logic [CNT_W-1:0]   cnt_q;

  // Add 3 to every nibble that is 5 or more before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[DIGIT_W*i +: DIGIT_W] >= 4'd5)
        bcd_adj[DIGIT_W*i +: DIGIT_W] = bcd_q[DIGIT_W*i +: DIGIT_W] + 4'd3;
    end
  end

  // Load clears the accumulator; each later cycle shifts in one binary bit, MSB first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      bin_q <= bin;
      bcd_q <= '0;
      cnt_q <= CNT_W'(VALUE_W);
    end else if (cnt_q != '0) begin
      bin_q <= {bin_q[VALUE_W-2:0], 1'b0};
      bcd_q <= {bcd_adj[BCD_W-2:0], bin_q[VALUE_W-1]};
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // High once the final iteration is in flight, so the caller can switch on that edge.
  assign ready = (cnt_q <= CNT_W'(1));
  assign bcd   = bcd_q;

endmodule

// File: rtl/result_ascii_streamer.sv
// Converts a 16-bit result to five ASCII digits and streams them with valid/ready.
module result_ascii_streamer
  import result_ascii_streamer_pkg::*;
#(
  parameter bit                LEAD_ZERO_BLANK = 1'b1,
  parameter logic [CHAR_W-1:0] BLANK_CHAR      = 8'h20
) (
  input  logic                    clk,
  input  logic                    rst,
  result_ascii_streamer_if.slave  bus
);

  localparam logic [POS_W-1:0] LAST_POS = POS_W'(NUM_DIGITS - 1);

  state_t             state_q, state_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               conv_load;
  logic               conv_ready;
  logic [BCD_W-1:0]   conv_bcd;
  logic [NUM_DIGITS-1:0] blank;
  logic [DIGIT_W-1:0] sel_digit;
  logic               sel_blank;
  logic [CHAR_W-1:0]  char_sel;

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .load  (conv_load),
    .bin   (bus.value_i),
    .bcd   (conv_bcd),
    .ready (conv_ready)
  );

  // State and column registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
    end
  end

  // Next-state logic: accept start in IDLE only, advance column on each transfer.
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    conv_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          conv_load = 1'b1;
          pos_d     = '0;
          state_d   = CONVERT;
        end
      end
      CONVERT: begin
        if (conv_ready) begin
          pos_d   = '0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (bus.char_ready) begin
          if (pos_q == LAST_POS) begin
            pos_d   = '0;
            state_d = DONE;
          end else begin
            pos_d = pos_q + POS_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Leading-zero mask: a digit blanks when it and everything above it are zero.
  always_comb begin
    logic zero_run;
    blank    = '0;
    zero_run = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      zero_run = zero_run & (bcd_digit(conv_bcd, i) == '0);
      blank[i] = LEAD_ZERO_BLANK && zero_run && (i != NUM_DIGITS - 1);
    end
  end

  // Pick the digit for the current column; held stable while the LCD stalls.
  always_comb begin
    sel_digit = '0;
    sel_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (pos_q == POS_W'(i)) begin
        sel_digit = bcd_digit(conv_bcd, i);
        sel_blank = blank[i];
      end
    end
    if (state_q != EMIT)
      char_sel = '0;
    else if (sel_blank)
      char_sel = BLANK_CHAR;
    else
      char_sel = ASCII_ZERO + CHAR_W'(sel_digit);
  end

  // Outputs decode only registered state, column and converter contents.
  assign bus.busy       = (state_q != IDLE);
  assign bus.char_valid = (state_q == EMIT);
  assign bus.done       = (state_q == DONE);
  assign bus.char_pos   = pos_q;
  assign bus.char_data  = char_sel;

endmodule

// File: tb/tb_result_ascii_streamer.sv
// Bench for result_ascii_streamer: blanking and non-blanking instances run in lock-step.
module tb_result_ascii_streamer;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  result_ascii_streamer_if bus ();
  result_ascii_streamer_if bus_nb ();

  assign bus_nb.start      = bus.start;
  assign bus_nb.value_i    = bus.value_i;
  assign bus_nb.char_ready = bus.char_ready;

  result_ascii_streamer #(.LEAD_ZERO_BLANK(1'b1), .BLANK_CHAR(8'h20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  result_ascii_streamer #(.LEAD_ZERO_BLANK(1'b0), .BLANK_CHAR(8'h20)) dut_nb (
    .clk (clk),
    .rst (rst),
    .bus (bus_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: character at column pos of the 5-digit decimal rendering of v.
  function automatic logic [7:0] exp_char(input int v, input int pos, input bit blank_en);
    int p10;
    p10 = 1;
    for (int k = 0; k < 4 - pos; k++) p10 = p10 * 10;
    if (blank_en && pos < 4 && (v / p10) == 0) return 8'h20;
    return 8'(8'h30 + ((v / p10) % 10));
  endfunction

  task automatic test_reset();
    if ({bus.busy, bus.char_valid, bus.done} !== 3'b000 || bus.char_data !== 8'h00 || bus.char_pos !== 3'd0) begin
      $display("FAIL reset_outputs: busy=%b valid=%b done=%b data=%h pos=%0d, required all zero",
               bus.busy, bus.char_valid, bus.done, bus.char_data, bus.char_pos);
      n_err++;
    end
    n_cmp++;
  endtask

  // One full conversion; optional stall at one column, random ready, and an ignored second start.
  task automatic run_conv(input int v, input int stall_pos, input int stall_len,
                          input bit rand_ready, input bit inject, input string name);
    int lat, idx, stall_left, guard, stray;
    bit rdy;
    logic [7:0] e, enb;
    @(negedge clk);
    bus.value_i = 16'(v);
    bus.start   = 1'b1;
    bus.char_ready = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    if (bus.busy !== 1'b1) begin
      $display("FAIL %s busy_after_start: got %b need 1", name, bus.busy); n_err++;
    end
    n_cmp++;
    while (!bus.char_valid && lat < 40) begin
      if (inject && lat == 5) begin
        bus.start = 1'b1; bus.value_i = 16'd12;
      end else begin
        bus.start = 1'b0;
        if (lat == 6) bus.value_i = 16'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;
    if (lat !== 17) begin
      $display("FAIL %s latency: got %0d cycles need 17", name, lat); n_err++;
    end
    n_cmp++;
    idx = 0; stall_left = stall_len; guard = 0;
    while (idx < 5 && guard < 200) begin
      guard++;
      e   = exp_char(v, idx, 1'b1);
      enb = exp_char(v, idx, 1'b0);
      if (bus.char_valid !== 1'b1 || bus.char_pos !== 3'(idx) || bus.char_data !== e) begin
        $display("FAIL %s char%0d: got valid=%b pos=%0d data=%h need valid=1 pos=%0d data=%h",
                 name, idx, bus.char_valid, bus.char_pos, bus.char_data, idx, e);
        n_err++;
      end
      n_cmp++;
      if (bus_nb.char_data !== enb) begin
        $display("FAIL %s noblank_char%0d: got %h need %h", name, idx, bus_nb.char_data, enb); n_err++;
      end
      n_cmp++;
      if (idx == stall_pos && stall_left > 0) begin
        rdy = 1'b0; stall_left--;
      end else if (rand_ready) begin
        rdy = 1'($urandom_range(0, 1));
      end else begin
        rdy = 1'b1;
      end
      bus.char_ready = rdy;
      @(posedge clk); #1;
      if (rdy) idx++;
    end
    if (idx != 5) begin
      $display("FAIL %s emit_timeout: got %0d chars need 5", name, idx); n_err++;
    end
    n_cmp++;
    bus.char_ready = 1'($urandom_range(0, 1));
    if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.char_valid !== 1'b0) begin
      $display("FAIL %s done_pulse: got done=%b busy=%b valid=%b need 1 1 0",
               name, bus.done, bus.busy, bus.char_valid);
      n_err++;
    end
    n_cmp++;
    @(posedge clk); #1;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      $display("FAIL %s back_to_idle: got done=%b busy=%b need 0 0", name, bus.done, bus.busy); n_err++;
    end
    n_cmp++;
    if (inject) begin
      stray = 0;
      for (int c = 0; c < 25; c++) begin
        if (bus.char_valid || bus.done || bus.busy || bus_nb.char_valid) stray++;
        @(posedge clk); #1;
      end
      if (stray != 0) begin
        $display("FAIL %s queued_start: got %0d active cycles need 0", name, stray); n_err++;
      end
      n_cmp++;
    end
    bus.char_ready = 1'b0;
  endtask

  task automatic test_basic();
    run_conv(1000, -1, 0, 1'b0, 1'b0, "v1000");
    run_conv(0, -1, 0, 1'b0, 1'b0, "v0");
    run_conv(65535, -1, 0, 1'b0, 1'b0, "v65535");
    run_conv(7, -1, 0, 1'b0, 1'b0, "v7");
  endtask

  // The '9' of 4096 sits in column 3; stall there and watch it hold.
  task automatic test_stall();
    run_conv(4096, 3, 3, 1'b0, 1'b0, "stall4096");
  endtask

  task automatic test_back_to_back();
    run_conv(345, -1, 0, 1'b0, 1'b1, "ignore_start");
  endtask

  task automatic test_abort();
    int guard, stray;
    @(negedge clk);
    bus.value_i = 16'd54321; bus.start = 1'b1; bus.char_ready = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    guard = 0;
    while (!bus.char_valid && guard < 40) begin
      @(posedge clk); #1; guard++;
    end
    bus.char_ready = 1'b1;
    @(posedge clk); #1;
    bus.char_ready = 1'b0;
    if (bus.char_valid !== 1'b1 || bus.char_pos !== 3'd1 || bus.char_data !== exp_char(54321, 1, 1'b1)) begin
      $display("FAIL abort_pos1: got valid=%b pos=%0d data=%h need 1 1 %h",
               bus.char_valid, bus.char_pos, bus.char_data, exp_char(54321, 1, 1'b1));
      n_err++;
    end
    n_cmp++;
    #2 rst = 1'b1;
    #1;
    if ({bus.busy, bus.char_valid, bus.done} !== 3'b000 || bus.char_data !== 8'h00 || bus.char_pos !== 3'd0) begin
      $display("FAIL abort_reset: busy=%b valid=%b done=%b data=%h pos=%0d, required all zero",
               bus.busy, bus.char_valid, bus.done, bus.char_data, bus.char_pos);
      n_err++;
    end
    n_cmp++;
    @(negedge clk);
    rst = 1'b0;
    bus.char_ready = 1'b1;
    stray = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (bus.char_valid || bus.done || bus.busy) stray++;
    end
    if (stray != 0) begin
      $display("FAIL abort_no_output: got %0d active cycles need 0", stray); n_err++;
    end
    n_cmp++;
    bus.char_ready = 1'b0;
    run_conv(9, -1, 0, 1'b0, 1'b0, "after_abort9");
  endtask

  task automatic test_random();
    int v;
    for (int t = 0; t < 12; t++) begin
      case (t % 4)
        0:       v = int'($urandom_range(0, 9));
        1:       v = int'($urandom_range(10, 999));
        default: v = int'($urandom_range(0, 65535));
      endcase
      run_conv(v, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), 1'b1, 1'b0, "random");
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.value_i = '0;
    bus.char_ready = 1'b0;
    #12;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_basic();
    test_stall();
    test_back_to_back();
    test_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
